// File: rtl/conv_axis_out_packer.sv
// Output packer: buffers convolution-core words in a FWFT FIFO and presents them as AXI4-Stream with per-frame tlast.
// Latency: a word written in cycle t appears on m_axis_tdata/tvalid at t+1 (no same-cycle bypass).
// Backpressure: core_stall is asserted from the registered fill level, which leaves room for PIPE_LAT in-flight words.
//
// Ports:
//   s_axis_aclk, s_axis_areset         : clock and synchronous active-high reset
//   core_tdata, core_tvalid            : word stream from the convolution core (no backpressure of its own)
//   core_stall                         : freezes the core pipeline while the FIFO is nearly full
//   m_axis_tdata/tvalid/tlast/tready   : AXI4-Stream master
//   frame_done, frame_cnt              : one-cycle pulse after a frame's last beat is accepted, and completed-frame counter
//   overflow_err                       : sticky flag, a core word was dropped because the FIFO was full
module conv_axis_out_packer #(
    parameter int WORD_WIDTH      = 128,
    parameter int BEATS_PER_FRAME = 16384,
    parameter int FIFO_DEPTH      = 16,
    parameter int PIPE_LAT        = 2,
    parameter int FRAME_CNT_W     = 16
) (
    input  logic                   s_axis_aclk,
    input  logic                   s_axis_areset,
    input  logic [WORD_WIDTH-1:0]  core_tdata,
    input  logic                   core_tvalid,
    output logic                   core_stall,
    output logic [WORD_WIDTH-1:0]  m_axis_tdata,
    output logic                   m_axis_tvalid,
    output logic                   m_axis_tlast,
    input  logic                   m_axis_tready,
    output logic                   frame_done,
    output logic [FRAME_CNT_W-1:0] frame_cnt,
    output logic                   overflow_err
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam int BW = (BEATS_PER_FRAME > 1) ? $clog2(BEATS_PER_FRAME) : 1;

    localparam logic [CW-1:0] FULL_CNT  = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] STALL_CNT = CW'(FIFO_DEPTH - PIPE_LAT);
    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS_PER_FRAME - 1);

    logic [WORD_WIDTH-1:0]  r_mem [FIFO_DEPTH];
    logic [AW-1:0]          r_wr_ptr;
    logic [AW-1:0]          r_rd_ptr;
    logic [CW-1:0]          r_count;
    logic [BW-1:0]          r_out_beat;
    logic                   r_frame_done;
    logic [FRAME_CNT_W-1:0] r_frame_cnt;
    logic                   r_overflow;

    logic w_tvalid;
    logic w_full;
    logic w_accept;
    logic w_last;
    logic w_write;
    logic w_drop;

    assign w_tvalid = (r_count != '0);
    assign w_full   = (r_count == FULL_CNT);
    assign w_accept = w_tvalid && m_axis_tready;
    assign w_last   = (r_out_beat == LAST_BEAT);
    // A write into a full FIFO still lands when the head is being accepted
    // this cycle: the read frees exactly the slot the write pointer targets.
    assign w_write  = core_tvalid && (!w_full || w_accept);
    assign w_drop   = core_tvalid && w_full && !w_accept;

    assign m_axis_tvalid = w_tvalid;
    assign m_axis_tdata  = r_mem[r_rd_ptr];
    assign m_axis_tlast  = w_tvalid && w_last;
    // Decoded from the registered count so the core sees a glitch-free stall
    // that does not depend on this cycle's tready.
    assign core_stall    = (r_count >= STALL_CNT);
    assign frame_done    = r_frame_done;
    assign frame_cnt     = r_frame_cnt;
    assign overflow_err  = r_overflow;

    // Storage carries no reset; its contents are only observable behind tvalid.
    always_ff @(posedge s_axis_aclk) begin
        if (!s_axis_areset && w_write) begin
            r_mem[r_wr_ptr] <= core_tdata;
        end
    end

    always_ff @(posedge s_axis_aclk) begin
        if (s_axis_areset) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_out_beat   <= '0;
            r_frame_done <= 1'b0;
            r_frame_cnt  <= '0;
            r_overflow   <= 1'b0;
        end else begin
            if (w_write) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_accept) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end

            if (w_write && !w_accept) begin
                r_count <= r_count + 1'b1;
            end else if (!w_write && w_accept) begin
                r_count <= r_count - 1'b1;
            end

            if (w_drop) begin
                r_overflow <= 1'b1;
            end

            r_frame_done <= w_accept && w_last;

            if (w_accept) begin
                if (w_last) begin
                    r_out_beat  <= '0;
                    r_frame_cnt <= r_frame_cnt + 1'b1;
                end else begin
                    r_out_beat  <= r_out_beat + 1'b1;
                end
            end
        end
    end

endmodule
